// File: rtl/maxpool_ctrl_conv_3_pkg.sv
// Shared constants, FSM encoding and helpers for the conv-3 max-pool sequencer.
package maxpool_ctrl_conv_3_pkg;

    localparam int unsigned POOL_K = 2;
    localparam int unsigned POOL_S = 2;

    localparam int unsigned N_C_DEF = 26;
    localparam int unsigned N_R_DEF = 26;

    localparam int unsigned POOL_NC = N_C_DEF / POOL_S;
    localparam int unsigned POOL_NR = N_R_DEF / POOL_S;
    localparam int unsigned POOL_N  = POOL_NC * POOL_NR;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_ctrl_conv_3_if.sv
// Control, conv-memory read and pool-write signals of the max-pool sequencer.
interface maxpool_ctrl_conv_3_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RADDR_W = 10,
    parameter int unsigned WADDR_W = 8
) ();

    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      ren;
    logic [RADDR_W-1:0]        radd;
    logic signed [DATA_W-1:0]  rdata;
    logic                      pool_wen;
    logic [WADDR_W-1:0]        pool_wadd;
    logic signed [DATA_W-1:0]  pool_data;

    modport master (
        input  start, rdata,
        output busy, done, ren, radd, pool_wen, pool_wadd, pool_data
    );

    modport slave (
        output start, rdata,
        input  busy, done, ren, radd, pool_wen, pool_wadd, pool_data
    );

endinterface

// File: rtl/maxpool_ctrl_conv_3_max4_acc.sv
// Signed load/compare accumulator over one 2x2 window; registers the window max on the last pixel.
module maxpool_ctrl_conv_3_max4_acc #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_vld,
    input  logic                     i_first,
    input  logic                     i_last,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_wen,
    output logic signed [DATA_W-1:0] o_data
);

    logic signed [DATA_W-1:0] r_acc;
    logic signed [DATA_W-1:0] r_data;
    logic                     r_wen;
    logic signed [DATA_W-1:0] w_cand;

    // Strict compare so a tie keeps the accumulator.
    always_comb begin
        w_cand = r_acc;
        if (i_first || (i_data > r_acc)) begin
            w_cand = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_data <= '0;
            r_wen  <= 1'b0;
        end else begin
            r_wen <= i_vld && i_last;
            if (i_vld) begin
                r_acc <= w_cand;
            end
            if (i_vld && i_last) begin
                r_data <= w_cand;
            end
        end
    end

    assign o_wen  = r_wen;
    assign o_data = r_data;

endmodule

// File: rtl/maxpool_ctrl_conv_3.sv
// 2x2/stride-2 max-pool sequencer: window-ordered conv memory reads, signed max, pooled writes.
module maxpool_ctrl_conv_3
    import maxpool_ctrl_conv_3_pkg::*;
#(
    parameter int unsigned N_C     = N_C_DEF,
    parameter int unsigned N_R     = N_R_DEF,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RADDR_W = 10,
    parameter int unsigned WADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    maxpool_ctrl_conv_3_if.master io_bus
);

    localparam int unsigned NC2  = N_C / POOL_S;
    localparam int unsigned NR2  = N_R / POOL_S;
    localparam int unsigned PC_W = cnt_w(NC2);
    localparam int unsigned PR_W = cnt_w(NR2);

    localparam logic [PC_W-1:0]    PC_LAST  = PC_W'(NC2 - 1);
    localparam logic [PR_W-1:0]    PR_LAST  = PR_W'(NR2 - 1);
    localparam logic [1:0]         K_LAST   = 2'(POOL_K * POOL_K - 1);
    localparam logic [RADDR_W-1:0] ONE      = RADDR_W'(1);
    localparam logic [RADDR_W-1:0] COL_STEP = RADDR_W'(N_C - 1);
    localparam logic [RADDR_W-1:0] WIN_STEP = RADDR_W'(POOL_S);
    // Row end skips the odd row and, for odd N_C, the dropped last column.
    localparam logic [RADDR_W-1:0] ROW_STEP = RADDR_W'(N_C + POOL_S + (N_C % 2));

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [RADDR_W-1:0]       r_radd;
    logic [RADDR_W-1:0]       r_base;
    logic [1:0]               r_k;
    logic [PC_W-1:0]          r_pc;
    logic [PR_W-1:0]          r_pr;
    logic                     r_vld_d;
    logic [1:0]               r_k_d;
    logic [WADDR_W-1:0]       r_wr_idx;
    logic [WADDR_W-1:0]       r_pool_wadd;
    logic                     r_done;

    logic                     w_ren;
    logic                     w_start_acc;
    logic                     w_last_rd;
    logic                     w_first;
    logic                     w_last;
    logic                     w_pool_wen;
    logic signed [DATA_W-1:0] w_pool_data;

    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        w_start_acc = 1'b0;
        w_last_rd   = (r_k == K_LAST) && (r_pc == PC_LAST) && (r_pr == PR_LAST);
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_state_nxt = StRead;
                    w_start_acc = 1'b1;
                end
            end
            StRead: begin
                w_ren = 1'b1;
                if (w_last_rd) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (w_pool_wen) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_radd      <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_pc        <= '0;
            r_pr        <= '0;
            r_vld_d     <= 1'b0;
            r_k_d       <= '0;
            r_wr_idx    <= '0;
            r_pool_wadd <= '0;
            r_done      <= 1'b0;
        end else begin
            // Delay line lines the pixel index up with rdata one cycle later.
            r_vld_d <= w_ren;
            r_k_d   <= r_k;
            r_done  <= (r_state == StDrain) && w_pool_wen;
            if (r_vld_d && (r_k_d == K_LAST)) begin
                r_pool_wadd <= r_wr_idx;
                r_wr_idx    <= r_wr_idx + WADDR_W'(1);
            end
            if (w_start_acc) begin
                r_radd   <= '0;
                r_base   <= '0;
                r_k      <= '0;
                r_pc     <= '0;
                r_pr     <= '0;
                r_wr_idx <= '0;
            end else if (w_ren) begin
                r_k <= r_k + 2'd1;
                unique case (r_k)
                    2'd0, 2'd2: r_radd <= r_radd + ONE;
                    2'd1:       r_radd <= r_radd + COL_STEP;
                    default: begin
                        // radd holds on the final read so it stays put while ren=0.
                        if (!w_last_rd) begin
                            if (r_pc == PC_LAST) begin
                                r_pc   <= '0;
                                r_pr   <= r_pr + PR_W'(1);
                                r_base <= r_base + ROW_STEP;
                                r_radd <= r_base + ROW_STEP;
                            end else begin
                                r_pc   <= r_pc + PC_W'(1);
                                r_base <= r_base + WIN_STEP;
                                r_radd <= r_base + WIN_STEP;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign w_first = (r_k_d == 2'd0);
    assign w_last  = (r_k_d == K_LAST);

    maxpool_ctrl_conv_3_max4_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (r_vld_d),
        .i_first (w_first),
        .i_last  (w_last),
        .i_data  (io_bus.rdata),
        .o_wen   (w_pool_wen),
        .o_data  (w_pool_data)
    );

    assign io_bus.busy      = (r_state != StIdle);
    assign io_bus.done      = r_done;
    assign io_bus.ren       = w_ren;
    assign io_bus.radd      = r_radd;
    assign io_bus.pool_wen  = w_pool_wen;
    assign io_bus.pool_wadd = r_pool_wadd;
    assign io_bus.pool_data = w_pool_data;

endmodule
